// File: rtl/nla_fp32_pkg.sv
// Shared FP32 constants, divider state encoding and operand helpers
// for the NLA_HW floating-point datapath (multiplier and divider).
package nla_fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0]      FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] FP32_INF_EXP = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } div_state_e;

    // Denormals count as zero: only the exponent field matters.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == '0;
    endfunction

    // Operand pairs that bypass the mantissa divider entirely.
    function automatic logic is_special(input logic [31:0] a,
                                        input logic [31:0] b);
        return (a[30:23] == FP32_INF_EXP) || (b[30:23] == FP32_INF_EXP)
            || is_zero(a) || is_zero(b);
    endfunction

endpackage

// File: rtl/mant_div_step.sv
// One combinational restoring-division step on the 24-bit significand.
// Kept standalone so a pipelined variant can unroll it.
module mant_div_step
    import nla_fp32_pkg::*;
(
    input  logic [25:0] rem,
    input  logic [23:0] div,
    output logic [25:0] rem_next,
    output logic        q_bit
);

    logic [25:0] w_div_ext;
    logic [25:0] w_diff;
    logic [25:0] w_sel;

    // Subtract when the divisor fits, then shift for the next bit.
    always_comb begin
        w_div_ext = {2'b00, div};
        w_diff    = rem - w_div_ext;
        q_bit     = (rem >= w_div_ext);
        w_sel     = q_bit ? w_diff : rem;
        rem_next  = w_sel << 1;
    end

endmodule

// File: rtl/divide_32.sv
// Iterative FP32 divider: one quotient bit per falling edge,
// denormals flushed to zero, result truncated toward zero.
module divide_32
    import nla_fp32_pkg::*;
(
    input  logic        clk_n,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        div_by_zero,
    output logic        overflow
);

    div_state_e         r_state;
    div_state_e         w_state_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [24:0]        r_q;
    logic [4:0]         r_cnt;
    logic [31:0]        r_result;
    logic               r_dbz;
    logic               r_ovf;
    logic               r_in_ready;

    logic               w_accept;
    logic               w_special;
    logic               w_nan;
    logic               w_sign;
    logic [25:0]        w_rem_nxt;
    logic               w_q_bit;
    logic signed [9:0]  w_exp_n;
    logic [22:0]        w_man_n;

    mant_div_step u_step (
        .rem      (r_rem),
        .div      (r_div),
        .rem_next (w_rem_nxt),
        .q_bit    (w_q_bit)
    );

    // State register.
    always_ff @(negedge clk_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_UNPACK;
            S_UNPACK: w_state_nxt = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (r_cnt == 5'd24) w_state_nxt = S_NORM;
            S_NORM:   w_state_nxt = S_DONE;
            S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs, operand classification and normalisation.
    always_comb begin
        w_accept  = r_in_ready && in_valid;
        out_valid = (r_state == S_DONE);
        in_ready  = r_in_ready;
        w_sign    = r_a[31] ^ r_b[31];
        w_special = is_special(r_a, r_b);
        w_nan     = (r_a[30:23] == FP32_INF_EXP)
                 || (r_b[30:23] == FP32_INF_EXP)
                 || (is_zero(r_a) && is_zero(r_b));
        w_exp_n   = r_q[24] ? r_exp : r_exp - 10'sd1;
        w_man_n   = r_q[24] ? r_q[23:1] : r_q[22:0];
    end

    // Datapath registers and result/flag capture.
    always_ff @(negedge clk_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_result <= '0;
                        r_dbz    <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    r_exp  <= $signed({2'b00, r_a[30:23]})
                            - $signed({2'b00, r_b[30:23]})
                            + $signed(10'(BIAS));
                    r_rem  <= {2'b01, r_a[MAN_W-1:0]};
                    r_div  <= {1'b1, r_b[MAN_W-1:0]};
                    r_q    <= '0;
                    r_cnt  <= '0;
                    if (w_nan) begin
                        r_result <= FP32_QNAN;
                    end else if (is_zero(r_b)) begin
                        r_result <= {w_sign, FP32_INF_EXP, 23'd0};
                        r_dbz    <= 1'b1;
                    end else if (is_zero(r_a)) begin
                        r_result <= {w_sign, 31'd0};
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[23:0], w_q_bit};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    if (w_exp_n >= 10'sd255) begin
                        r_result <= {r_sign, FP32_INF_EXP, 23'd0};
                        r_ovf    <= 1'b1;
                    end else if (w_exp_n <= 10'sd0) begin
                        r_result <= {r_sign, 31'd0};
                    end else begin
                        r_result <= {r_sign, w_exp_n[7:0], w_man_n};
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result      = r_result;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_divide_32.sv
// Directed scoreboard bench for divide_32: DUT acts on falling edges,
// the bench drives and samples on rising edges.
module tb_divide_32;

    logic        clk_n;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        div_by_zero;
    logic        overflow;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    divide_32 dut (
        .clk_n       (clk_n),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Result      (Result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk_n = 1'b1;
    always #5 clk_n = ~clk_n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk_n);
        @(posedge clk_n);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic op(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] r,
                      input logic        dbz,
                      input logic        ovf,
                      input int          lat_exp,
                      input int          hold);
        int   lat;
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        A = a;
        B = b;
        sb.push_back('{res: r, dbz: dbz, ovf: ovf});
        @(negedge clk_n);
        @(posedge clk_n);
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 0;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("busy_ready", 32'(in_ready), 32'd0);
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", Result, e.res);
            chk("hold_flags", 32'({div_by_zero, overflow}),
                32'({e.dbz, e.ovf}));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        chk("result", Result, e.res);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(negedge clk_n);
        @(posedge clk_n);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_ready", 32'(in_ready), 32'd1);

        op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 27, 0);
        op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 0, 0, 27, 0);
        op(32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000, 0, 0, 27, 0);
        op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0, 1, 0);
        op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 0, 1, 0);
        op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 0, 0, 1, 0);
        op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 0, 0, 1, 0);
        op(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0, 0, 1, 0);
        op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 0, 1, 27, 0);
        op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 27, 0);
        op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 27, 10);

        wait_ready();
        in_valid = 1'b1;
        A = 32'h40C0_0000;
        B = 32'h4000_0000;
        @(negedge clk_n);
        @(posedge clk_n);
        in_valid = 1'b0;
        repeat (11) @(negedge clk_n);
        @(posedge clk_n);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_result", Result, 32'd0);
        step();
        chk("mid_rst_ready2", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 27, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
